// File: rtl/amm_burst_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amm_burst_responder_pkg
// Description : Shared Avalon-MM interface constants and the responder FSM
//               state type used by amm_burst_responder.
// Revision    : 1.0  initial release
// ============================================================================
package amm_burst_responder_pkg;

    localparam int AMM_ADDR_W  = 32;
    localparam int AMM_DATA_W  = 512;
    localparam int AMM_BURST_W = 11;
    localparam int DATA_B_W    = AMM_DATA_W / 8;
    localparam int ADDR_B_W    = $clog2(DATA_B_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_ISSUE = 2'd2
    } resp_state_t;

endpackage : amm_burst_responder_pkg
`default_nettype wire

// File: rtl/amm_resp_ram.sv
`default_nettype none
// ============================================================================
// Module      : amm_resp_ram
// Description : Simple dual-port RAM, 2^ADDR_W words of DATA_W bits, with a
//               per-byte write enable and a registered read port. Contents
//               are not reset. The read register only updates on i_rd_en.
// Ports       : clk       - clock
//               i_wr_en   - write strobe
//               i_wr_addr - write word address
//               i_wr_be   - byte enables for the write
//               i_wr_data - write data
//               i_rd_en   - read strobe
//               i_rd_addr - read word address
//               o_rd_data - registered read data (one cycle after i_rd_en)
// Revision    : 1.0  initial release
// ============================================================================
module amm_resp_ram #(
    parameter  int ADDR_W = 8,
    parameter  int DATA_W = 512,
    localparam int BYTES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [BYTES-1:0]  i_wr_be,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : amm_resp_ram
`default_nettype wire

// File: rtl/amm_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : amm_burst_responder
// Description : Avalon-MM burst slave emulating a small byte-enabled memory.
//               Stores write bursts, answers read bursts after a fixed
//               RD_LATENCY (legal 2..16) and can corrupt one byte lane of one
//               word on read to exercise a checker's error path.
// Ports       : clk_i / rst_i            - clock, sync active-high reset
//               amm_*_i / amm_*_o        - Avalon-MM slave interface
//               inj_en_i/word_i/byte_i   - read fault injection control
//               proto_err_o              - sticky protocol-violation flag
//               wr_beats_o / rd_beats_o  - saturating beat counters
// Revision    : 1.0  initial release
// ============================================================================
module amm_burst_responder #(
    parameter  int AMM_ADDR_W  = amm_burst_responder_pkg::AMM_ADDR_W,
    parameter  int AMM_DATA_W  = amm_burst_responder_pkg::AMM_DATA_W,
    parameter  int AMM_BURST_W = amm_burst_responder_pkg::AMM_BURST_W,
    parameter  int RAM_ADDR_W  = 8,
    parameter  int RD_LATENCY  = 4,
    localparam int DATA_B_W    = AMM_DATA_W / 8,
    localparam int ADDR_B_W    = $clog2(DATA_B_W)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AMM_ADDR_W-1:0]  amm_address_i,
    input  logic                   amm_read_i,
    input  logic                   amm_write_i,
    input  logic [AMM_DATA_W-1:0]  amm_writedata_i,
    input  logic [DATA_B_W-1:0]    amm_byteenable_i,
    input  logic [AMM_BURST_W-1:0] amm_burstcount_i,
    output logic                   amm_waitrequest_o,
    output logic [AMM_DATA_W-1:0]  amm_readdata_o,
    output logic                   amm_readdatavalid_o,
    input  logic                   inj_en_i,
    input  logic [RAM_ADDR_W-1:0]  inj_word_i,
    input  logic [ADDR_B_W-1:0]    inj_byte_i,
    output logic                   proto_err_o,
    output logic [31:0]            wr_beats_o,
    output logic [31:0]            rd_beats_o
);

    import amm_burst_responder_pkg::*;

    // Stages between the RAM read register and the output register.
    localparam int DL_N = RD_LATENCY - 2;

    resp_state_t            r_state;
    logic [RAM_ADDR_W-1:0]  r_word;
    logic [AMM_BURST_W-1:0] r_remaining;
    logic                   r_proto_err;
    logic [31:0]            r_wr_beats;
    logic [31:0]            r_rd_beats;
    logic                   r_rdv;
    logic [AMM_DATA_W-1:0]  r_rdata;
    logic                   r_s0_vld;
    logic                   r_s0_inj;
    logic [ADDR_B_W-1:0]    r_s0_lane;

    logic [RAM_ADDR_W-1:0]  w_cmd_word;
    logic [AMM_BURST_W-1:0] w_burst_len;
    logic                   w_wr_en;
    logic [RAM_ADDR_W-1:0]  w_wr_addr;
    logic                   w_rd_en;
    logic [RAM_ADDR_W-1:0]  w_rd_addr;
    logic [AMM_DATA_W-1:0]  w_ram_q;
    logic [AMM_DATA_W-1:0]  w_inj_mask;
    logic [AMM_DATA_W-1:0]  w_s0_data;
    logic                   w_dl_vld;
    logic [AMM_DATA_W-1:0]  w_dl_data;
    logic                   w_unused;

    // Byte offset bits and upper alias bits are don't-care.
    assign w_unused    = ^amm_address_i;
    assign w_cmd_word  = amm_address_i[ADDR_B_W +: RAM_ADDR_W];
    assign w_burst_len = (amm_burstcount_i == '0) ? AMM_BURST_W'(1) : amm_burstcount_i;

    // Beat 0 of a read is issued in the accept cycle so that the pipeline
    // depth alone (RAM register + DL_N stages + output register) equals
    // RD_LATENCY. RD_ISSUE then covers beats 1..n-1.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_word;
        w_rd_en   = 1'b0;
        w_rd_addr = r_word;
        if (!rst_i) begin
            case (r_state)
                IDLE: begin
                    if (amm_write_i) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = w_cmd_word;
                    end else if (amm_read_i) begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = w_cmd_word;
                    end
                end
                WR_BURST: w_wr_en = amm_write_i;
                RD_ISSUE: w_rd_en = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_remaining <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (amm_write_i) begin
                        if (amm_read_i) begin
                            r_proto_err <= 1'b1;
                        end
                        if (w_burst_len > AMM_BURST_W'(1)) begin
                            r_state     <= WR_BURST;
                            r_remaining <= w_burst_len - AMM_BURST_W'(1);
                            r_word      <= w_cmd_word + RAM_ADDR_W'(1);
                        end
                    end else if (amm_read_i) begin
                        if (w_burst_len > AMM_BURST_W'(1)) begin
                            r_state     <= RD_ISSUE;
                            r_remaining <= w_burst_len - AMM_BURST_W'(1);
                            r_word      <= w_cmd_word + RAM_ADDR_W'(1);
                        end
                    end
                end
                WR_BURST: begin
                    if (amm_read_i) begin
                        r_proto_err <= 1'b1;
                    end
                    if (amm_write_i) begin
                        r_word      <= r_word + RAM_ADDR_W'(1);
                        r_remaining <= r_remaining - AMM_BURST_W'(1);
                        if (r_remaining == AMM_BURST_W'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                RD_ISSUE: begin
                    r_word      <= r_word + RAM_ADDR_W'(1);
                    r_remaining <= r_remaining - AMM_BURST_W'(1);
                    if (r_remaining == AMM_BURST_W'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    amm_resp_ram #(
        .ADDR_W (RAM_ADDR_W),
        .DATA_W (AMM_DATA_W)
    ) u_ram (
        .clk       (clk_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_be   (amm_byteenable_i),
        .i_wr_data (amm_writedata_i),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    // Injection decision is taken at issue and travels with the RAM read.
    always_ff @(posedge clk_i) begin
        r_s0_inj  <= inj_en_i && (w_rd_addr == inj_word_i);
        r_s0_lane <= inj_byte_i;
        if (rst_i) begin
            r_s0_vld <= 1'b0;
        end else begin
            r_s0_vld <= w_rd_en;
        end
    end

    always_comb begin
        w_inj_mask = '0;
        if (r_s0_inj) begin
            w_inj_mask[{r_s0_lane, 3'b000} +: 8] = 8'hFF;
        end
    end

    assign w_s0_data = w_ram_q ^ w_inj_mask;

    generate
        if (DL_N > 0) begin : g_delay
            logic [DL_N-1:0]       r_vld;
            logic [AMM_DATA_W-1:0] r_data [DL_N];

            always_ff @(posedge clk_i) begin
                r_data[0] <= w_s0_data;
                for (int i = 1; i < DL_N; i++) begin
                    r_data[i] <= r_data[i-1];
                end
                if (rst_i) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= r_s0_vld;
                    for (int i = 1; i < DL_N; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            assign w_dl_vld  = r_vld[DL_N-1];
            assign w_dl_data = r_data[DL_N-1];
        end else begin : g_no_delay
            assign w_dl_vld  = r_s0_vld;
            assign w_dl_data = w_s0_data;
        end
    endgenerate

    // Output register holds the last beat while readdatavalid is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdv      <= 1'b0;
            r_rdata    <= '0;
            r_rd_beats <= '0;
            r_wr_beats <= '0;
        end else begin
            r_rdv <= w_dl_vld;
            if (w_dl_vld) begin
                r_rdata <= w_dl_data;
                if (r_rd_beats != '1) begin
                    r_rd_beats <= r_rd_beats + 32'd1;
                end
            end
            if (w_wr_en && (r_wr_beats != '1)) begin
                r_wr_beats <= r_wr_beats + 32'd1;
            end
        end
    end

    assign amm_waitrequest_o   = rst_i || (r_state == RD_ISSUE);
    assign amm_readdata_o      = r_rdata;
    assign amm_readdatavalid_o = r_rdv;
    assign proto_err_o         = r_proto_err;
    assign wr_beats_o          = r_wr_beats;
    assign rd_beats_o          = r_rd_beats;

endmodule : amm_burst_responder
`default_nettype wire
